rr_priority_encoder: RTL

- Sequential counterpart of the one-hot decoder: collects requests on 2**output_width one-hot request lines and re-encodes them into binary indices.
- Serves pending requests one at a time, in round-robin order, over a valid/ready output handshake.
- Used wherever several sources raise lines that a downstream unit consumes as a binary index: interrupt lines, bank requests, register-select events.

---
 rtl/rr_priority_encoder.sv | 72 +++++++
 1 files changed

// File: rtl/rr_priority_encoder.sv
// Round-robin re-encoder of one-hot request lines into a binary index; out is visible 2 cycles after req is sampled.
// When out_ready is low, the output is held and pending requests accumulate; when ready is held high, it issues one grant per cycle.
module rr_priority_encoder #(
  parameter int output_width = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [2**output_width-1:0]   req,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [output_width-1:0]      out,
  output logic [2**output_width-1:0]   pending,
  output logic                         busy
);

  localparam int num_req = 2**output_width;

  logic [output_width-1:0] pointer;
  logic [output_width-1:0] cand;
  logic [output_width-1:0] sel_idx;
  logic                    sel_found;
  logic                    slot_free;
  logic                    load;
  logic [num_req-1:0]      clear_mask;
  logic [num_req-1:0]      req_masked;

  // Rotating search starting at pointer; index arithmetic wraps in output_width bits.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < num_req; k++) begin
      cand = pointer + output_width'(k);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign slot_free  = !out_valid || out_ready;
  assign load       = slot_free && sel_found;
  assign clear_mask = load ? (num_req'(1) << sel_idx) : '0;
  assign req_masked = req & {num_req{enable}};
  assign busy       = (|pending) || out_valid;

  // A request arriving on a bit being granted this cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      pointer   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      pending <= (pending & ~clear_mask) | req_masked;
      if (slot_free) begin
        if (sel_found) begin
          out       <= sel_idx;
          out_valid <= 1'b1;
          pointer   <= sel_idx + output_width'(1);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  hold_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out)));

endmodule
